// File: rtl/sram_mux_arbiter.sv
// sram_mux_arbiter: N-channel arbiter and strobe sequencer for one asynchronous SRAM.
// Each transaction runs IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> FINISH -> IDLE.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   req/wr          per-channel request level and op (1 = write)
//   addr/wdata      packed per-channel address / write data (ch i at [i*W +: W])
//   done            one-cycle completion pulse for the served channel (FINISH)
//   rdata           last read result, shared by all channels
//   busy            high whenever the sequencer is not idle
//   grant_id        channel currently or most recently served
//   sram_*          SRAM address, bidirectional data bus, active-low EN/OE/WE
module sram_mux_arbiter #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned RR_MODE     = 0,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        wr,
    input  logic [NUM_CH*ADDR_W-1:0] addr,
    input  logic [NUM_CH*DATA_W-1:0] wdata,
    output logic [NUM_CH-1:0]        done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic [CH_W-1:0]          grant_id,
    output logic [ADDR_W-1:0]        sram_addr,
    inout  wire  [DATA_W-1:0]        sram_data,
    output logic                     sram_en,
    output logic                     sram_oe,
    output logic                     sram_we
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]     id_q, ptr_q;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wd_q, rdata_q;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic                en_q, en_d, oe_q, oe_d, we_q, we_d, drv_q, drv_d;

    logic                hi_found, lo_found, grant;
    logic [CH_W-1:0]     hi_id, lo_id, win_id;
    logic                sel_wr;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wd;

    // Lowest active channel overall, and lowest active channel above the RR pointer.
    // Round-robin prefers the latter and wraps to the former.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found = 1'b1;
                lo_id    = CH_W'(i);
                if (CH_W'(i) > ptr_q) begin
                    hi_found = 1'b1;
                    hi_id    = CH_W'(i);
                end
            end
        end
    end

    assign win_id = ((RR_MODE != 0) && hi_found) ? hi_id : lo_id;
    assign grant  = (state_q == S_IDLE) && lo_found;

    // Mux out the winning channel's operation fields.
    always_comb begin
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_wd   = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (win_id == CH_W'(i)) begin
                sel_wr   = wr[i];
                sel_addr = addr[i*ADDR_W +: ADDR_W];
                sel_wd   = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next-state logic; ACCESS length set by a down-counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (grant) state_d = S_SETUP;
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            end
            S_ACCESS: begin
                if (cnt_q == '0) state_d = S_FINISH;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign wr_d = grant ? sel_wr : wr_q;

    // Strobe/done decode from the next state so the registered pins line up with the state.
    always_comb begin
        en_d   = 1'b1;
        oe_d   = 1'b1;
        we_d   = 1'b1;
        drv_d  = 1'b0;
        done_d = '0;
        case (state_d)
            S_SETUP: begin
                en_d  = 1'b0;
                oe_d  = wr_d;
                drv_d = wr_d;
            end
            S_ACCESS: begin
                en_d  = 1'b0;
                oe_d  = wr_d;
                we_d  = !wr_d;
                drv_d = wr_d;
            end
            S_FINISH: begin
                // Address and data stay put for write hold time.
                drv_d = wr_d;
                for (int i = 0; i < int'(NUM_CH); i++) begin
                    done_d[i] = (id_q == CH_W'(i));
                end
            end
            default: ;
        endcase
    end

    // Output pin registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q   <= 1'b1;
            oe_q   <= 1'b1;
            we_q   <= 1'b1;
            drv_q  <= 1'b0;
            done_q <= '0;
        end else begin
            en_q   <= en_d;
            oe_q   <= oe_d;
            we_q   <= we_d;
            drv_q  <= drv_d;
            done_q <= done_d;
        end
    end

    // Transaction latch at grant, RR pointer, and read capture on the last ACCESS edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q    <= '0;
            ptr_q   <= CH_W'(NUM_CH - 1);
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
        end else begin
            wr_q <= wr_d;
            if (grant) begin
                id_q   <= win_id;
                ptr_q  <= win_id;
                addr_q <= sel_addr;
                wd_q   <= sel_wd;
            end
            if ((state_q == S_ACCESS) && (cnt_q == '0) && !wr_q) begin
                rdata_q <= sram_data;
            end
        end
    end

    assign sram_data = drv_q ? wd_q : {DATA_W{1'bz}};
    assign sram_addr = addr_q;
    assign sram_en   = en_q;
    assign sram_oe   = oe_q;
    assign sram_we   = we_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign grant_id  = id_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_mux_arbiter.sv
// Testbench for sram_mux_arbiter: two 3-channel instances (fixed priority and
// round-robin, WAIT_CYCLES=2), each on its own behavioural SRAM with a pulled-up bus.
// Directed steps cover reset, strobe timing, priority order, back-to-back and
// mid-transaction reset; random rounds are scored against a grant-order/memory model.
module tb_sram_mux_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req   [2];
    logic [2:0]  wr    [2];
    logic [53:0] addr  [2];
    logic [47:0] wdata [2];
    logic [2:0]  done  [2];
    logic [15:0] rdata [2];
    logic        busy  [2];
    logic [1:0]  gid   [2];
    logic [17:0] saddr [2];
    logic        sen   [2];
    logic        soe   [2];
    logic        swe   [2];
    wire  [15:0] bus0, bus1;

    logic [15:0] sram_mem [2][262144];
    logic [15:0] ref_mem [int];
    logic [15:0] exp_rd [2];
    int          last_win [2];
    logic [17:0] pool [8];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    sram_mux_arbiter #(.NUM_CH(3), .ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(2), .RR_MODE(0)) u_fix (
        .clk(clk), .rst(rst), .req(req[0]), .wr(wr[0]), .addr(addr[0]), .wdata(wdata[0]),
        .done(done[0]), .rdata(rdata[0]), .busy(busy[0]), .grant_id(gid[0]),
        .sram_addr(saddr[0]), .sram_data(bus0), .sram_en(sen[0]), .sram_oe(soe[0]), .sram_we(swe[0])
    );

    sram_mux_arbiter #(.NUM_CH(3), .ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(2), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .req(req[1]), .wr(wr[1]), .addr(addr[1]), .wdata(wdata[1]),
        .done(done[1]), .rdata(rdata[1]), .busy(busy[1]), .grant_id(gid[1]),
        .sram_addr(saddr[1]), .sram_data(bus1), .sram_en(sen[1]), .sram_oe(soe[1]), .sram_we(swe[1])
    );

    // Behavioural async SRAMs: drive on EN&OE low, store while EN&WE low.
    pullup (bus0);
    pullup (bus1);
    assign bus0 = (!sen[0] && !soe[0] && swe[0]) ? sram_mem[0][saddr[0]] : 16'hzzzz;
    assign bus1 = (!sen[1] && !soe[1] && swe[1]) ? sram_mem[1][saddr[1]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!sen[0] && !swe[0]) sram_mem[0][saddr[0]] <= bus0;
        if (!sen[1] && !swe[1]) sram_mem[1][saddr[1]] <= bus1;
    end

    function automatic int key(input bit u, input logic [17:0] a);
        return {13'd0, u, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_op(input bit u, input logic [1:0] ch, input logic w,
                          input logic [17:0] a, input logic [15:0] d);
        wr[u][ch]             = w;
        addr[u][ch*18 +: 18]  = a;
        wdata[u][ch*16 +: 16] = d;
    endtask

    // Reference arbitration: fixed = lowest index; RR = first active after the last winner.
    function automatic int pick(input logic [2:0] pend, input int last, input bit rr);
        int c;
        for (int k = 0; k < 3; k++) begin
            c = rr ? (last + 1 + k) % 3 : k;
            if (pend[c[1:0]]) return c;
        end
        return 0;
    endfunction

    // Waits (bounded) for a done pulse; checks its spacing, vector and grant_id.
    task automatic wait_done(input bit u, input int exp_ch, input int exp_gap, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done[u] == 3'b000 && n < 20);
        chk({tag, "_gap"}, n, exp_gap);
        chk({tag, "_done"}, 32'(done[u]), 32'(3'b001 << exp_ch));
        chk({tag, "_gid"}, 32'(gid[u]), exp_ch);
    endtask

    // Single op on an otherwise idle instance; returns in the following IDLE cycle.
    task automatic do_op(input bit u, input logic [1:0] ch, input logic w,
                         input logic [17:0] a, input logic [15:0] d, input string tag);
        set_op(u, ch, w, a, d);
        req[u][ch] = 1'b1;
        wait_done(u, int'(ch), 4, tag);
        if (w) begin
            ref_mem[key(u, a)] = d;
        end else begin
            exp_rd[u] = ref_mem[key(u, a)];
            chk({tag, "_rdata"}, 32'(rdata[u]), 32'(exp_rd[u]));
        end
        req[u][ch]  = 1'b0;
        last_win[u] = int'(ch);
        @(negedge clk);
    endtask

    task automatic new_op(input bit u, input logic [1:0] ch);
        logic [17:0] a;
        a = pool[3'($urandom_range(0, 7))];
        if (!ref_mem.exists(key(u, a)) || $urandom_range(0, 1) == 1)
            set_op(u, ch, 1'b1, a, 16'($urandom_range(0, 65534)));
        else
            set_op(u, ch, 1'b0, a, 16'($urandom));
    endtask

    // Random round: requesters hold req until done, sometimes re-request or join late.
    task automatic run_random(input bit u, input bit rr, input int n_ops);
        logic [2:0]  pend;
        logic [1:0]  c;
        logic [17:0] a;
        int win, last, issued, cyc, exp_cyc;
        last   = last_win[u];
        pend   = 3'($urandom_range(1, 7));
        issued = 0;
        for (int k = 0; k < 3; k++) begin
            if (pend[k]) begin
                new_op(u, 2'(k));
                issued++;
            end
        end
        req[u]  = pend;
        win     = pick(pend, last, rr);
        cyc     = 0;
        exp_cyc = 4;
        while (pend != 3'b000 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            chk("rnd_done", 32'(done[u]), (cyc == exp_cyc) ? 32'(3'b001 << win) : 32'd0);
            if (cyc == exp_cyc) begin
                c = 2'(win);
                a = addr[u][c*18 +: 18];
                chk("rnd_gid", 32'(gid[u]), win);
                if (wr[u][c]) begin
                    ref_mem[key(u, a)] = wdata[u][c*16 +: 16];
                    chk("rnd_rdata_keep", 32'(rdata[u]), 32'(exp_rd[u]));
                end else begin
                    exp_rd[u] = ref_mem[key(u, a)];
                    chk("rnd_rdata", 32'(rdata[u]), 32'(exp_rd[u]));
                end
                pend[c] = 1'b0;
                last    = win;
                if (issued < n_ops && $urandom_range(0, 1) == 1) begin
                    new_op(u, c);
                    pend[c] = 1'b1;
                    issued++;
                end
                for (int k = 0; k < 3; k++) begin
                    if (!pend[k] && issued < n_ops && $urandom_range(0, 3) == 0) begin
                        new_op(u, 2'(k));
                        pend[k] = 1'b1;
                        issued++;
                    end
                end
                req[u] = pend;
                if (pend != 3'b000) begin
                    win     = pick(pend, last, rr);
                    exp_cyc = cyc + 5;
                end
            end
        end
        chk("rnd_drained", 32'(pend), 32'd0);
        req[u]      = 3'b000;
        last_win[u] = last;
        @(negedge clk);
    endtask

    initial begin
        pool = '{18'h00012, 18'h3FFFF, 18'h00000, 18'h00001, 18'h00040, 18'h1ABCD, 18'h20000, 18'h00777};
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = '0; wr[i] = '0; addr[i] = '0; wdata[i] = '0;
            last_win[i] = 2;
            exp_rd[i] = 16'h0000;
        end
        repeat (3) @(negedge clk);

        // Reset values on both instances.
        for (int i = 0; i < 2; i++) begin
            chk("rst_en",    32'(sen[i[0]]), 1);
            chk("rst_oe",    32'(soe[i[0]]), 1);
            chk("rst_we",    32'(swe[i[0]]), 1);
            chk("rst_addr",  32'(saddr[i[0]]), 0);
            chk("rst_done",  32'(done[i[0]]), 0);
            chk("rst_rdata", 32'(rdata[i[0]]), 0);
            chk("rst_busy",  32'(busy[i[0]]), 0);
            chk("rst_gid",   32'(gid[i[0]]), 0);
        end
        chk("rst_bus0", 32'(bus0), 32'hFFFF);
        chk("rst_bus1", 32'(bus1), 32'hFFFF);
        rst = 1'b1;
        @(negedge clk);

        // Single write ch1: 0x5A5A to 0x3FFFF, WE low exactly in ACCESS; post-grant input changes ignored.
        set_op(1'b0, 2'd1, 1'b1, 18'h3FFFF, 16'h5A5A);
        req[0] = 3'b010;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("wr_we",   32'(swe[0]), (k == 2 || k == 3) ? 0 : 1);
            chk("wr_en",   32'(sen[0]), (k <= 3) ? 0 : 1);
            chk("wr_oe",   32'(soe[0]), 1);
            chk("wr_addr", 32'(saddr[0]), 32'h3FFFF);
            chk("wr_bus",  32'(bus0), 32'h5A5A);
            chk("wr_done", 32'(done[0]), (k == 4) ? 32'b010 : 0);
            if (k == 1) set_op(1'b0, 2'd1, 1'b0, 18'h00000, 16'h1234);
        end
        req[0] = 3'b000;
        ref_mem[key(1'b0, 18'h3FFFF)] = 16'h5A5A;
        last_win[0] = 1;
        @(negedge clk);
        chk("wr_release", 32'(bus0), 32'hFFFF);
        chk("wr_idle",    32'(busy[0]), 0);

        // Preload 0xBEEF at 0x12, then the detailed single read on ch0.
        do_op(1'b0, 2'd2, 1'b1, 18'h00012, 16'hBEEF, "pre");
        set_op(1'b0, 2'd0, 1'b0, 18'h00012, 16'h0000);
        req[0] = 3'b001;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("rd_oe",   32'(soe[0]), (k <= 3) ? 0 : 1);
            chk("rd_we",   32'(swe[0]), 1);
            chk("rd_addr", 32'(saddr[0]), 32'h12);
            chk("rd_done", 32'(done[0]), (k == 4) ? 32'b001 : 0);
        end
        chk("rd_rdata", 32'(rdata[0]), 32'hBEEF);
        req[0] = 3'b000;
        exp_rd[0] = 16'hBEEF;
        @(negedge clk);
        do_op(1'b0, 2'd0, 1'b0, 18'h3FFFF, 16'h0000, "rd_back");

        // Fixed priority: all three held; ch0 re-requests once, then each drops on its done.
        set_op(1'b0, 2'd0, 1'b0, 18'h00012, 16'h0);
        set_op(1'b0, 2'd1, 1'b0, 18'h3FFFF, 16'h0);
        set_op(1'b0, 2'd2, 1'b0, 18'h00012, 16'h0);
        req[0] = 3'b111;
        wait_done(1'b0, 0, 4, "fp_a");
        chk("fp_a_rd", 32'(rdata[0]), 32'hBEEF);
        wait_done(1'b0, 0, 5, "fp_b");
        req[0][0] = 1'b0;
        wait_done(1'b0, 1, 5, "fp_c");
        chk("fp_c_rd", 32'(rdata[0]), 32'h5A5A);
        req[0][1] = 1'b0;
        wait_done(1'b0, 2, 5, "fp_d");
        chk("fp_d_rd", 32'(rdata[0]), 32'hBEEF);
        req[0][2] = 1'b0;
        exp_rd[0] = 16'hBEEF;
        last_win[0] = 2;
        @(negedge clk);

        // Round-robin: three writes held continuously -> 0,1,2,0,1,2 at 5-cycle spacing.
        set_op(1'b1, 2'd0, 1'b1, 18'h00100, 16'h1111);
        set_op(1'b1, 2'd1, 1'b1, 18'h00101, 16'h2222);
        set_op(1'b1, 2'd2, 1'b1, 18'h00102, 16'h3333);
        req[1] = 3'b111;
        for (int j = 0; j < 6; j++) begin
            wait_done(1'b1, j % 3, (j == 0) ? 4 : 5, "rr");
        end
        req[1] = 3'b000;
        ref_mem[key(1'b1, 18'h00100)] = 16'h1111;
        ref_mem[key(1'b1, 18'h00101)] = 16'h2222;
        ref_mem[key(1'b1, 18'h00102)] = 16'h3333;
        @(negedge clk);
        do_op(1'b1, 2'd0, 1'b0, 18'h00101, 16'h0, "rr_rb");

        // Back-to-back read then write on ch2: one IDLE cycle between, rdata untouched by the write.
        set_op(1'b0, 2'd2, 1'b0, 18'h3FFFF, 16'h0);
        req[0] = 3'b100;
        wait_done(1'b0, 2, 4, "b2b_rd");
        chk("b2b_rd_val", 32'(rdata[0]), 32'h5A5A);
        set_op(1'b0, 2'd2, 1'b1, 18'h00040, 16'h1357);
        @(negedge clk);
        chk("b2b_idle", 32'(busy[0]), 0);
        @(negedge clk);
        chk("b2b_busy", 32'(busy[0]), 1);
        wait_done(1'b0, 2, 3, "b2b_wr");
        chk("b2b_keep", 32'(rdata[0]), 32'h5A5A);
        req[0] = 3'b000;
        ref_mem[key(1'b0, 18'h00040)] = 16'h1357;
        @(negedge clk);
        do_op(1'b0, 2'd1, 1'b0, 18'h00040, 16'h0, "b2b_rb");

        // Reset during ACCESS of a write: strobes and bus release at once, no done afterwards.
        set_op(1'b0, 2'd0, 1'b1, 18'h00777, 16'h2468);
        req[0] = 3'b001;
        @(negedge clk);
        @(negedge clk);
        chk("mid_we_pre", 32'(swe[0]), 0);
        rst = 1'b0;
        req[0] = 3'b000;
        #1;
        chk("mid_we",    32'(swe[0]), 1);
        chk("mid_en",    32'(sen[0]), 1);
        chk("mid_bus",   32'(bus0), 32'hFFFF);
        chk("mid_busy",  32'(busy[0]), 0);
        chk("mid_rdata", 32'(rdata[0]), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("mid_nodone", 32'(done[0]), 0);
        end
        last_win[0] = 2;
        last_win[1] = 2;
        exp_rd[0] = 16'h0000;
        exp_rd[1] = 16'h0000;

        // Randomised rounds on both arbitration modes.
        for (int r = 0; r < 6; r++) begin
            run_random(1'b0, 1'b0, 12);
            run_random(1'b1, 1'b1, 12);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
